// File: rtl/mat_pkg.sv
// Shared definitions for the triangular matrix multiplier: FSM states,
// default geometry / number format, and the accumulator sizing rule.
package mat_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LOADED  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int DEF_N    = 3;
  localparam int DEF_SIZE = 16;
  localparam int DEF_FRAC = 12;

  // Full-precision product plus headroom for summing up to n products.
  function automatic int acc_width(input int size, input int n);
    return 2 * size + $clog2(n);
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Signed fixed-point multiply-accumulate with output scaling: one product per
// enabled cycle, optional round-half-up, then saturate or wrap to SIZE bits.
// The scaled result is combinational on the running sum so the caller can
// capture it in the same cycle as the final product.
module fx_mac
  import mat_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int FRAC  = DEF_FRAC,
  parameter int ROUND = 1,
  parameter int SAT   = 1,
  parameter int ACC_W = acc_width(DEF_SIZE, DEF_N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic            first,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] res,
  output logic            sat
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int EW      = ACC_W + 1;
  localparam int HALF_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] HALF =
    (ROUND != 0 && FRAC > 0) ? (EW'(1) << HALF_SH) : EW'(0);
  localparam logic [SIZE-1:0] MAX_VAL = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

  logic signed [2*SIZE-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [EW-1:0]     rnd_s;
  logic signed [EW-1:0]     shr_s;
  logic [EW-SIZE:0]         hi_s;
  logic                     ovf_s;

  // Product, running sum (restarted on the first term of a dot product) and scaling.
  always_comb begin
    prod_s     = $signed(a) * $signed(b);
    prod_ext_s = {{(ACC_W-2*SIZE){prod_s[2*SIZE-1]}}, prod_s};
    if (first) begin
      sum_s = prod_ext_s;
    end else begin
      sum_s = acc_r + prod_ext_s;
    end
    rnd_s = {sum_s[ACC_W-1], sum_s} + HALF;
    shr_s = rnd_s >>> FRAC;
    hi_s  = shr_s[EW-1:SIZE-1];
    ovf_s = ~((&hi_s) | ~(|hi_s));
  end

  // Clamp out-of-range results when saturating, otherwise keep the low bits.
  always_comb begin
    res = shr_s[SIZE-1:0];
    sat = 1'b0;
    if (SAT != 0 && ovf_s) begin
      res = shr_s[EW-1] ? MIN_VAL : MAX_VAL;
      sat = 1'b1;
    end else begin
      res = shr_s[SIZE-1:0];
      sat = 1'b0;
    end
  end

  // Accumulator register, advanced once per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum_s;
    end
  end

endmodule

// File: rtl/tri_mat_mul.sv
// C = A * B where A is upper triangular (R-inverse) and B is Q-transpose.
// Pairs of elements are streamed in row-major, a start pulse runs the
// triangular MAC schedule, and results are drained row-major with a
// valid/ready handshake.
module tri_mat_mul
  import mat_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SIZE  = DEF_SIZE,
  parameter int FRAC  = DEF_FRAC,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] a_elem,
  input  logic [SIZE-1:0] b_elem,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_elem,
  output logic            out_last,
  output logic            sat_flag
);

  localparam int NN    = N * N;
  localparam int IW    = $clog2(NN);
  localparam int RW    = $clog2(N);
  localparam int ACC_W = acc_width(SIZE, N);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_t state_r, state_s;

  logic [SIZE-1:0] a_mem_r [NN];
  logic [SIZE-1:0] b_mem_r [NN];
  logic [SIZE-1:0] c_mem_r [NN];

  logic [IW-1:0]   load_cnt_r, drain_idx_r;
  logic [RW-1:0]   i_r, j_r, k_r;
  logic            load_ready_r, busy_r, out_valid_r, out_last_r, sat_flag_r;
  logic [SIZE-1:0] out_elem_r;

  logic            load_acc_s, start_acc_s, mac_en_s, k_first_s, k_last_s;
  logic            mac_done_s, out_hs_s, mac_sat_s;
  logic [IW-1:0]   a_idx_s, b_idx_s, c_idx_s, next_idx_s;
  logic [SIZE-1:0] mac_res_s;

  assign load_ready = load_ready_r;
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign out_elem   = out_elem_r;
  assign out_last   = out_last_r;
  assign sat_flag   = sat_flag_r;

  // Handshake qualifiers and schedule addressing; only k >= i is ever visited,
  // so the lower triangle of A never contributes.
  always_comb begin
    load_acc_s  = load_valid & load_ready_r & ~clear;
    start_acc_s = (state_r == LOADED) & start;
    mac_en_s    = (state_r == COMPUTE);
    k_first_s   = (k_r == i_r);
    k_last_s    = (k_r == LAST_ROW);
    mac_done_s  = mac_en_s & k_last_s & (i_r == LAST_ROW) & (j_r == LAST_ROW);
    out_hs_s    = out_valid_r & out_ready;
    a_idx_s     = IW'(i_r) * IW'(N) + IW'(k_r);
    b_idx_s     = IW'(k_r) * IW'(N) + IW'(j_r);
    c_idx_s     = IW'(i_r) * IW'(N) + IW'(j_r);
    next_idx_s  = drain_idx_r + IW'(1);
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = load_acc_s ? LOAD : IDLE;
        LOAD:    state_s = (load_acc_s && load_cnt_r == LAST_IDX) ? LOADED : LOAD;
        LOADED:  state_s = start ? COMPUTE : LOADED;
        COMPUTE: state_s = mac_done_s ? DRAIN : COMPUTE;
        DRAIN:   state_s = (out_hs_s && out_last_r) ? IDLE : DRAIN;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register plus flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      load_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      load_ready_r <= (state_s == IDLE) || (state_s == LOAD);
      busy_r       <= (state_s == COMPUTE);
    end
  end

  // Operand capture: A and B element pairs written at the load counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_r <= '0;
      for (int p = 0; p < NN; p++) begin
        a_mem_r[p] <= '0;
        b_mem_r[p] <= '0;
      end
    end else if (clear) begin
      load_cnt_r <= '0;
    end else if (load_acc_s) begin
      a_mem_r[load_cnt_r] <= a_elem;
      b_mem_r[load_cnt_r] <= b_elem;
      load_cnt_r <= (load_cnt_r == LAST_IDX) ? '0 : load_cnt_r + IW'(1);
    end
  end

  // MAC schedule: rows i, columns j, inner k from i to N-1; result stored on k = N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r        <= '0;
      j_r        <= '0;
      k_r        <= '0;
      sat_flag_r <= 1'b0;
      for (int p = 0; p < NN; p++) begin
        c_mem_r[p] <= '0;
      end
    end else if (clear) begin
      i_r <= '0;
      j_r <= '0;
      k_r <= '0;
    end else if (start_acc_s) begin
      i_r        <= '0;
      j_r        <= '0;
      k_r        <= '0;
      sat_flag_r <= 1'b0;
    end else if (mac_en_s) begin
      if (k_last_s) begin
        c_mem_r[c_idx_s] <= mac_res_s;
        if (mac_sat_s) begin
          sat_flag_r <= 1'b1;
        end
        if (j_r == LAST_ROW) begin
          if (i_r == LAST_ROW) begin
            i_r <= '0;
            j_r <= '0;
            k_r <= '0;
          end else begin
            i_r <= i_r + RW'(1);
            j_r <= '0;
            k_r <= i_r + RW'(1);
          end
        end else begin
          j_r <= j_r + RW'(1);
          k_r <= i_r;
        end
      end else begin
        k_r <= k_r + RW'(1);
      end
    end
  end

  // Drain: present C row-major, hold while stalled, advance on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_elem_r  <= '0;
      drain_idx_r <= '0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_elem_r  <= '0;
      drain_idx_r <= '0;
    end else if (mac_done_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= 1'b0;
      out_elem_r  <= c_mem_r[0];
      drain_idx_r <= '0;
    end else if (out_hs_s) begin
      if (out_last_r) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        drain_idx_r <= '0;
      end else begin
        out_elem_r  <= c_mem_r[next_idx_s];
        out_last_r  <= (next_idx_s == LAST_IDX);
        drain_idx_r <= next_idx_s;
      end
    end
  end

  fx_mac #(
    .SIZE  (SIZE),
    .FRAC  (FRAC),
    .ROUND (ROUND),
    .SAT   (SAT),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (mac_en_s),
    .first (k_first_s),
    .a     (a_mem_r[a_idx_s]),
    .b     (b_mem_r[b_idx_s]),
    .res   (mac_res_s),
    .sat   (mac_sat_s)
  );

endmodule

// File: doc/tri_mat_mul.md
TRI_MAT_MUL -- requirements
Module: tri_mat_mul

Interface
REQ-001 SHALL have parameter N, default 3, matrix dimension (2..8).
REQ-002 SHALL have parameter SIZE, default 16, signed element width.
REQ-003 SHALL have parameter FRAC, default 12, fraction bits of the input and output fixed-point format.
REQ-004 SHALL have parameter ROUND, default 1, where 1 means round-half-up and 0 means arithmetic-shift truncate.
REQ-005 SHALL have parameter SAT, default 1, where 1 means saturate to the SIZE signed range and 0 means wrap.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-009 SHALL have port load_valid, input, 1, element pair present.
REQ-010 SHALL have port load_ready, output, 1, block accepts a pair.
REQ-011 SHALL have port a_elem, input, SIZE, upper-triangular A (R-inverse) element, row-major.
REQ-012 SHALL have port b_elem, input, SIZE, B (Q-transpose) element, row-major.
REQ-013 SHALL have port start, input, 1, begin compute.
REQ-014 SHALL have port busy, output, 1, high in COMPUTE.
REQ-015 SHALL have port out_valid, output, 1, out_elem valid.
REQ-016 SHALL have port out_ready, input, 1, consumer accepts.
REQ-017 SHALL have port out_elem, output, SIZE, result C[i][j], row-major.
REQ-018 SHALL have port out_last, output, 1, high with C[N-1][N-1].
REQ-019 SHALL have port sat_flag, output, 1, sticky: some result element saturated in the current matrix.

Function
REQ-020 SHALL compute C[i][j] = sum over k=i..N-1 of A[i][k]*B[k][j], ignoring loaded A[i][k] for k<i (treated as zero).
REQ-021 SHALL use FSM states IDLE, LOAD, LOADED, COMPUTE, DRAIN; IDLE->LOAD on first accepted pair; LOAD->LOADED on the N*N-th pair; LOADED->COMPUTE on start; COMPUTE->DRAIN after the last MAC; DRAIN->IDLE on handshake of out_last.
REQ-022 SHALL assert load_ready only in IDLE and LOAD; a pair is accepted when load_valid and load_ready are both high on a clock edge.
REQ-023 SHALL ignore start in every state except LOADED.
REQ-024 SHALL use one signed multiplier with a 2*SIZE+clog2(N) accumulator performing one product per cycle; COMPUTE lasts exactly N*N*(N+1)/2 cycles (18 for N=3).
REQ-025 SHALL clear the accumulator at k=i and, at k=N-1, write the scaled result into the result store in the same cycle.
REQ-026 SHALL scale as follows: ROUND=1 adds 2^(FRAC-1) and then shifts right arithmetically by FRAC; ROUND=0 shifts only. With SAT=1, out-of-range values clamp to 2^(SIZE-1)-1 or -2^(SIZE-1) and set sat_flag; SAT=0 keeps the low SIZE bits.
REQ-027 SHALL present out_valid only in DRAIN, with the first element on the cycle after COMPUTE ends.
REQ-028 SHALL hold out_elem, out_last and out_valid stable while out_ready is low, and advance one element per handshake.
REQ-029 SHALL clear sat_flag on entry to COMPUTE and hold it through DRAIN and IDLE.
REQ-030 SHALL, on clear in any state, go to IDLE next cycle, zero the load/compute/drain counters and deassert out_valid; stored matrices are not required to be zeroed.
REQ-031 SHALL, if clear and a load handshake coincide, give clear priority and discard the pair.

Reset
REQ-032 SHALL, on rst_n low, immediately set state IDLE, all counters 0, out_valid 0, out_last 0, busy 0, sat_flag 0, out_elem 0 and load_ready 0.
REQ-033 SHALL set load_ready 1 on the first clock edge after rst_n deassertion.
REQ-034 SHALL reset internal matrix storage to 0.

Structure
REQ-035 SHALL place the FSM state enum, the default N/SIZE/FRAC constants and the accumulator-width function in a shared package mat_pkg.
REQ-036 SHALL isolate multiply, accumulate, round and saturate in one sub-module fx_mac, parametrised by SIZE, FRAC, ROUND, SAT and ACC_W.

Verification
REQ-037 SHALL cover: N=3, A=identity (0x1000 on the diagonal), B rows {0x1000,0x2000,0x3000} -> C=B, 18 busy cycles, out_last on the 9th output.
REQ-038 SHALL cover: lower triangle of A loaded with 0x7FFF, otherwise identity -> C=B unchanged.
REQ-039 SHALL cover: SAT=1, A[0][0]=B[0][0]=0x7FFF -> C[0][0]=0x7FFF and sat_flag=1; SAT=0 -> wrapped low 16 bits and sat_flag=0.
REQ-040 SHALL cover: ROUND check, A[0][0]=0x0001, B[0][0]=0x0800 -> C[0][0]=0x0001 with ROUND=1 and 0x0000 with ROUND=0.
REQ-041 SHALL cover: out_ready held low 5 cycles during DRAIN -> out_elem stable, and no element lost or duplicated.
REQ-042 SHALL cover: rst_n pulsed mid-COMPUTE, then clear mid-DRAIN -> outputs at reset values, load_ready=1, and the next full matrix computes correctly.
